// File: rtl/rv_mem_pkg.sv
// Shared definitions for the RV32I data-memory path.
// Holds the FUNCT3 access-type encodings, the load/store unit state enum,
// the byte-strobe constants and the access legality checks.
package rv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] STRB_NONE = 4'b0000;
    localparam logic [3:0] STRB_B    = 4'b0001;
    localparam logic [3:0] STRB_H    = 4'b0011;
    localparam logic [3:0] STRB_W    = 4'b1111;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StFin,
        StFault
    } lsu_state_t;

    // Unused encodings, plus unsigned variants on stores (SBU/SHU do not exist).
    function automatic logic is_illegal(input logic we, input logic [2:0] f3);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (f3)
            F3_H, F3_HU: mis = addr_lo[0];
            F3_W:        mis = (addr_lo != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: selects the addressed lane of a memory word and
// sign- or zero-extends it according to the access type.
// Ports:
//   funct3_i  - access type (B/H/W/BU/HU)
//   addr_lo_i - byte offset within the word
//   rdata_i   - raw 32-bit memory word
//   data_o    - extended load result
module lsu_load_align
    import rv_mem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [31:0] lane;

    always_comb begin
        lane   = rdata_i >> {addr_lo_i, 3'b000};
        data_o = lane;
        case (funct3_i)
            F3_B:    data_o = {{24{lane[7]}}, lane[7:0]};
            F3_H:    data_o = {{16{lane[15]}}, lane[15:0]};
            F3_BU:   data_o = {24'h000000, lane[7:0]};
            F3_HU:   data_o = {16'h0000, lane[15:0]};
            default: data_o = lane;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit. Takes the ALU result as effective address, runs a
// request/grant/response handshake with data memory, builds byte strobes and
// lane-replicated store data, and returns extended load data.
// Ports:
//   CLK, RST            - clock, synchronous active-high reset
//   START, WE, FUNCT3   - operation request from the core (sampled in IDLE)
//   ADDR, WDATA         - effective address and store data
//   RDATA               - extended load result, held until the next load
//   DONE, ERR, BUSY     - completion pulse, fault flag, stall
//   MEM_REQ..MEM_WDATA  - registered memory request side
//   MEM_GNT, MEM_RVALID, MEM_RDATA - memory responses
module load_store_unit
    import rv_mem_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        WE,
    input  logic [2:0]  FUNCT3,
    input  logic [31:0] ADDR,
    input  logic [31:0] WDATA,
    output logic [31:0] RDATA,
    output logic        DONE,
    output logic        ERR,
    output logic        BUSY,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDR,
    output logic [3:0]  MEM_WSTRB,
    output logic [31:0] MEM_WDATA,
    input  logic        MEM_GNT,
    input  logic        MEM_RVALID,
    input  logic [31:0] MEM_RDATA
);

    lsu_state_t  state_q;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;

    logic [3:0]  strb_nx;
    logic [31:0] wdata_nx;
    logic [31:0] load_data;
    logic        fault;

    assign fault = is_illegal(WE, FUNCT3) || is_misaligned(FUNCT3, ADDR[1:0]);

    // Store alignment from the live request; only used on the IDLE->REQ edge.
    always_comb begin
        strb_nx  = STRB_W;
        wdata_nx = WDATA;
        case (FUNCT3[1:0])
            2'b00: begin
                strb_nx  = STRB_B << ADDR[1:0];
                wdata_nx = {4{WDATA[7:0]}};
            end
            2'b01: begin
                strb_nx  = ADDR[1] ? (STRB_H << 2) : STRB_H;
                wdata_nx = {2{WDATA[15:0]}};
            end
            default: begin
                strb_nx  = STRB_W;
                wdata_nx = WDATA;
            end
        endcase
        if (!WE) begin
            strb_nx = STRB_NONE;
        end
    end

    // Load path uses the latched type/offset, not the live core inputs.
    lsu_load_align u_load_align (
        .funct3_i  (funct3_q),
        .addr_lo_i (addr_lo_q),
        .rdata_i   (MEM_RDATA),
        .data_o    (load_data)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            we_q      <= 1'b0;
            funct3_q  <= 3'b000;
            addr_lo_q <= 2'b00;
            RDATA     <= 32'h0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
            BUSY      <= 1'b0;
            MEM_REQ   <= 1'b0;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= 32'h0;
            MEM_WSTRB <= STRB_NONE;
            MEM_WDATA <= 32'h0;
        end else begin
            DONE <= 1'b0;
            ERR  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (START) begin
                        we_q      <= WE;
                        funct3_q  <= FUNCT3;
                        addr_lo_q <= ADDR[1:0];
                        BUSY      <= 1'b1;
                        if (fault) begin
                            state_q <= StFault;
                            DONE    <= 1'b1;
                            ERR     <= 1'b1;
                        end else begin
                            state_q   <= StReq;
                            MEM_REQ   <= 1'b1;
                            MEM_WE    <= WE;
                            MEM_ADDR  <= {ADDR[31:2], 2'b00};
                            MEM_WSTRB <= strb_nx;
                            MEM_WDATA <= wdata_nx;
                        end
                    end
                end
                StReq: begin
                    if (MEM_GNT) begin
                        MEM_REQ <= 1'b0;
                        MEM_WE  <= 1'b0;
                        if (we_q) begin
                            state_q <= StFin;
                            DONE    <= 1'b1;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (MEM_RVALID) begin
                        RDATA   <= load_data;
                        state_q <= StFin;
                        DONE    <= 1'b1;
                    end
                end
                StFin, StFault: begin
                    state_q <= StIdle;
                    BUSY    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    BUSY    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit: stores, loads with sign
// and zero extension, delayed grant, faults, back-to-back ops and reset
// abort with a stale read response.
module tb_load_store_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        WE = 1'b0;
    logic [2:0]  FUNCT3 = 3'b000;
    logic [31:0] ADDR = 32'h0;
    logic [31:0] WDATA = 32'h0;
    logic [31:0] RDATA;
    logic        DONE, ERR, BUSY;
    logic        MEM_REQ, MEM_WE;
    logic [31:0] MEM_ADDR;
    logic [3:0]  MEM_WSTRB;
    logic [31:0] MEM_WDATA;
    logic        MEM_GNT = 1'b0;
    logic        MEM_RVALID = 1'b0;
    logic [31:0] MEM_RDATA = 32'h0;

    int n_checks = 0;
    int n_fails  = 0;

    // Captured per-operation observations.
    int          done_cyc;
    int          req_cnt;
    logic        err_seen;
    logic        busy_c1;
    logic        busy_after;
    logic        done_after;
    logic        stable;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [3:0]  cap_strb;
    logic [31:0] cap_wdata;
    int          stray_done;

    load_store_unit dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .WE         (WE),
        .FUNCT3     (FUNCT3),
        .ADDR       (ADDR),
        .WDATA      (WDATA),
        .RDATA      (RDATA),
        .DONE       (DONE),
        .ERR        (ERR),
        .BUSY       (BUSY),
        .MEM_REQ    (MEM_REQ),
        .MEM_WE     (MEM_WE),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_WSTRB  (MEM_WSTRB),
        .MEM_WDATA  (MEM_WDATA),
        .MEM_GNT    (MEM_GNT),
        .MEM_RVALID (MEM_RVALID),
        .MEM_RDATA  (MEM_RDATA)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issues one op in the current cycle (cycle 0) and plays memory: grant
    // after gnt_delay request cycles, read data the cycle after grant.
    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int gnt_delay,
                          input logic [31:0] word);
        logic rv_next;
        START    = 1'b1;
        WE       = we;
        FUNCT3   = f3;
        ADDR     = addr;
        WDATA    = wdata;
        rv_next  = 1'b0;
        done_cyc = -1;
        req_cnt  = 0;
        err_seen = 1'b0;
        busy_c1  = 1'b0;
        stable   = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            START      = 1'b0;
            MEM_GNT    = 1'b0;
            MEM_RVALID = 1'b0;
            if (i == 1) busy_c1 = BUSY;
            if (rv_next) begin
                MEM_RVALID = 1'b1;
                MEM_RDATA  = word;
                rv_next    = 1'b0;
            end
            if (MEM_REQ) begin
                req_cnt++;
                if (req_cnt == 1) begin
                    cap_we    = MEM_WE;
                    cap_addr  = MEM_ADDR;
                    cap_strb  = MEM_WSTRB;
                    cap_wdata = MEM_WDATA;
                end else if (MEM_WE !== cap_we || MEM_ADDR !== cap_addr ||
                             MEM_WSTRB !== cap_strb || MEM_WDATA !== cap_wdata) begin
                    stable = 1'b0;
                end
                if (req_cnt > gnt_delay) begin
                    MEM_GNT = 1'b1;
                    if (!we) rv_next = 1'b1;
                end
            end
            if (DONE) begin
                done_cyc = i;
                err_seen = ERR;
                break;
            end
        end
        MEM_GNT    = 1'b0;
        MEM_RVALID = 1'b0;
        tick();
        busy_after = BUSY;
        done_after = DONE;
    endtask

    initial begin
        // Reset
        tick();
        tick();
        RST = 1'b0;
        check("rst_rdata", RDATA, 32'h0);
        check("rst_busy", {31'h0, BUSY}, 32'h0);
        check("rst_req", {31'h0, MEM_REQ}, 32'h0);
        check("rst_wstrb", {28'h0, MEM_WSTRB}, 32'h0);
        check("rst_done", {30'h0, DONE, ERR}, 32'h0);

        // SW, immediate grant
        run_op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 32'h0);
        check("sw_done_cyc", done_cyc, 32'd2);
        check("sw_err", {31'h0, err_seen}, 32'h0);
        check("sw_addr", cap_addr, 32'h100);
        check("sw_strb", {28'h0, cap_strb}, 32'hF);
        check("sw_wdata", cap_wdata, 32'hDEADBEEF);
        check("sw_we", {31'h0, cap_we}, 32'h1);
        check("sw_busy_c1", {31'h0, busy_c1}, 32'h1);
        check("sw_busy_after", {30'h0, busy_after, done_after}, 32'h0);

        // SB at offset 3 (back-to-back with the previous op)
        run_op(1'b1, 3'b000, 32'h103, 32'h000000A5, 0, 32'h0);
        check("sb_done_cyc", done_cyc, 32'd2);
        check("sb_addr", cap_addr, 32'h100);
        check("sb_strb", {28'h0, cap_strb}, 32'h8);
        check("sb_wdata", cap_wdata, 32'hA5A5A5A5);

        // SH upper half
        run_op(1'b1, 3'b001, 32'h102, 32'hFFFF1234, 0, 32'h0);
        check("sh_strb", {28'h0, cap_strb}, 32'hC);
        check("sh_wdata", cap_wdata, 32'h12341234);

        // LB / LBU at offset 2
        run_op(1'b0, 3'b000, 32'h202, 32'h0, 0, 32'h1280FF34);
        check("lb_done_cyc", done_cyc, 32'd3);
        check("lb_rdata", RDATA, 32'hFFFFFF80);
        check("lb_strb", {28'h0, cap_strb}, 32'h0);
        check("lb_we", {31'h0, cap_we}, 32'h0);
        check("lb_addr", cap_addr, 32'h200);
        run_op(1'b0, 3'b100, 32'h202, 32'h0, 0, 32'h1280FF34);
        check("lbu_rdata", RDATA, 32'h00000080);

        // LH low half, negative
        run_op(1'b0, 3'b001, 32'h200, 32'h0, 0, 32'h00008001);
        check("lh_rdata", RDATA, 32'hFFFF8001);

        // LHU with grant delayed by 3 cycles
        run_op(1'b0, 3'b101, 32'h202, 32'h0, 3, 32'h8001FFFF);
        check("lhu_rdata", RDATA, 32'h00008001);
        check("lhu_req_cycles", req_cnt, 32'd4);
        check("lhu_stable", {31'h0, stable}, 32'h1);
        check("lhu_done_cyc", done_cyc, 32'd6);

        // Misaligned LW: fault at cycle 1, no request, RDATA held
        run_op(1'b0, 3'b010, 32'h206, 32'h0, 0, 32'hFFFFFFFF);
        check("lw_mis_done_cyc", done_cyc, 32'd1);
        check("lw_mis_err", {31'h0, err_seen}, 32'h1);
        check("lw_mis_req", req_cnt, 32'd0);
        check("lw_mis_rdata", RDATA, 32'h00008001);
        check("lw_mis_busy_after", {31'h0, busy_after}, 32'h0);

        // Illegal FUNCT3=011
        run_op(1'b0, 3'b011, 32'h300, 32'h0, 0, 32'hFFFFFFFF);
        check("f3_011_done_cyc", done_cyc, 32'd1);
        check("f3_011_err", {31'h0, err_seen}, 32'h1);
        check("f3_011_req", req_cnt, 32'd0);
        check("f3_011_rdata", RDATA, 32'h00008001);

        // Store with unsigned type is illegal
        run_op(1'b1, 3'b100, 32'h300, 32'h11, 0, 32'h0);
        check("sbu_err", {31'h0, err_seen}, 32'h1);
        check("sbu_req", req_cnt, 32'd0);

        // Reset while in WAIT, then a stale response
        START  = 1'b1;
        WE     = 1'b0;
        FUNCT3 = 3'b010;
        ADDR   = 32'h400;
        tick();
        START = 1'b0;
        check("abort_req_c1", {31'h0, MEM_REQ}, 32'h1);
        MEM_GNT = 1'b1;
        tick();
        MEM_GNT = 1'b0;
        RST     = 1'b1;
        tick();
        RST = 1'b0;
        check("abort_req", {31'h0, MEM_REQ}, 32'h0);
        check("abort_busy", {31'h0, BUSY}, 32'h0);
        check("abort_rdata", RDATA, 32'h0);
        MEM_RVALID = 1'b1;
        MEM_RDATA  = 32'hCAFEBABE;
        stray_done = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            MEM_RVALID = 1'b0;
            if (DONE || BUSY) stray_done++;
        end
        check("abort_no_done", stray_done, 32'd0);
        check("abort_rdata_after", RDATA, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
